uart_debug_loader: RTL and testbench
====================================

UART_DEBUG_LOADER -- requirements
Module: uart_debug_loader

Interface
REQ-001 SHALL have parameter NB_WORD, default 32, loaded and dumped word width; multiple of 8, from 8 to 64.
REQ-002 SHALL have parameter NB_ADDR, default 32, write-address width.
REQ-003 SHALL have parameter ADDR_STEP, default 4, address increment per loaded word.
REQ-004 SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, load terminator word.
REQ-005 SHALL have ports, clock and reset first:
  i_clk  in  1  single clock; all logic on rising edge
  i_reset  in  1  asynchronous, active-high reset
  i_rx_data  in  8  received UART byte
  i_rx_done  in  1  one-cycle pulse; i_rx_data valid
  i_tx_done  in  1  one-cycle pulse; transmitter finished a byte
  i_dump_word  in  NB_WORD  word to dump (pc/register/memory debug data)
  o_wr_en  out  1  one-cycle instruction-memory write strobe
  o_wr_addr  out  NB_ADDR  write address
  o_wr_data  out  NB_WORD  write data
  o_step  out  1  one-cycle single-step pulse to the pipeline
  o_run  out  1  level; free-run enable to the pipeline
  o_tx_data  out  8  byte to transmit
  o_tx_start  out  1  one-cycle transmit request
  o_busy  out  1  high in any state other than IDLE
  o_cksum_err  out  1  sticky checksum mismatch flag

Function
REQ-006 SHALL implement FSM states IDLE, LOAD, DUMP, DUMP_WAIT, plus CKSUM when REQ-021 applies.
REQ-007 In IDLE, on i_rx_done, the block SHALL decode commands: 0x4C 'L' -> LOAD with o_wr_addr=0 and byte count=0; 0x53 'S' -> o_step pulse on the next cycle, ignored while o_run=1; 0x52 'R' -> o_run=1; 0x50 'P' -> o_run=0; 0x44 'D' -> latch i_dump_word and go to DUMP; any other byte is ignored.
REQ-008 In LOAD, bytes SHALL assemble MSB-first; after NB_WORD/8 bytes, o_wr_en SHALL pulse exactly one cycle after the last i_rx_done, with the assembled o_wr_data and the current o_wr_addr.
REQ-009 o_wr_addr SHALL increment by ADDR_STEP on the cycle after each o_wr_en and wrap modulo 2^NB_ADDR.
REQ-010 An assembled word equal to HALT_WORD SHALL still be written, then the FSM SHALL go to IDLE (or CKSUM per REQ-021).
REQ-011 Loading SHALL NOT be allowed while o_run=1: 'L' is ignored until 'P' is received.
REQ-012 In DUMP, the block SHALL pulse o_tx_start one cycle with o_tx_data = the next latched byte, MSB-first, then go to DUMP_WAIT.
REQ-013 In DUMP_WAIT, i_tx_done SHALL return the FSM to DUMP for the next byte, or to IDLE after byte NB_WORD/8.
REQ-014 i_rx_done SHALL be ignored in DUMP and DUMP_WAIT; i_tx_done SHALL be ignored outside DUMP_WAIT.
REQ-015 o_tx_data SHALL hold its value until the next o_tx_start.
REQ-016 At most one of o_wr_en, o_step, o_tx_start SHALL be high in any cycle.

Reset
REQ-017 On i_reset, all outputs, the FSM (IDLE), the byte counter, the shift register and the checksum SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-018 A reset mid-LOAD SHALL discard the partial word, with no o_wr_en issued.
REQ-019 A reset mid-DUMP SHALL abort the transfer, with no further o_tx_start.

Configuration
REQ-020 Macro DEBUG_LOADER_CHECKSUM_EN SHALL select the checksum feature.
REQ-021 With DEBUG_LOADER_CHECKSUM_EN defined: XOR all loaded bytes, including HALT_WORD bytes; after HALT_WORD go to CKSUM; the next received byte SHALL be compared and o_cksum_err set on mismatch; clear o_cksum_err at 'L'; then go to IDLE.
REQ-022 Without the macro, there SHALL be no CKSUM state, and o_cksum_err SHALL be constant 0.

Verification
REQ-023 Load: 'L',12,34,56,78,FF,FF,FF,FF -> o_wr_en twice: (addr 0, 0x12345678), (addr 4, 0xFFFFFFFF); then o_busy=0.
REQ-024 Dump: i_dump_word=0xDEADBEEF, 'D', i_tx_done returned 20 cycles after each start -> o_tx_data DE,AD,BE,EF; four o_tx_start pulses; then IDLE.
REQ-025 Run/step: 'R' then 'S' -> o_run=1 and no o_step; 'P' then 'S' -> o_run=0 and one o_step pulse.
REQ-026 Reset after 'L',12,34 -> no o_wr_en; a following 'L',AA,BB,CC,DD,FF,FF,FF,FF writes 0xAABBCCDD at addr 0.
REQ-027 Checksum (macro on): 'L',01,02,03,04,FF,FF,FF,FF,04 -> o_cksum_err=0; last byte 05 -> o_cksum_err=1.
REQ-028 Wrap: NB_ADDR=4, load 5 words -> addresses 0,4,8,C,0.

Source files
------------

// File: rtl/uart_debug_loader.sv
// uart_debug_loader: UART command front end for a pipelined CPU debug unit.
// Commands: 'L' load program words, 'S' single step, 'R' run, 'P' pause,
// 'D' dump one debug word back over the transmitter.
// Handshake: i_rx_done / i_tx_done are one-cycle pulses; i_rx_data is valid only
// while i_rx_done is high. o_tx_start is a one-cycle request, and the next byte is
// not issued until i_tx_done returns in DUMP_WAIT.
// Optional feature: define DEBUG_LOADER_CHECKSUM_EN to enable the trailing XOR
// checksum byte after a load (adds the CKSUM state and a live o_cksum_err).
module uart_debug_loader #(
  parameter int                 NB_WORD   = 32,
  parameter int                 NB_ADDR   = 32,
  parameter int                 ADDR_STEP = 4,
  parameter logic [NB_WORD-1:0] HALT_WORD = NB_WORD'(32'hFFFFFFFF)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_WORD-1:0] i_dump_word,
  output logic               o_wr_en,
  output logic [NB_ADDR-1:0] o_wr_addr,
  output logic [NB_WORD-1:0] o_wr_data,
  output logic               o_step,
  output logic               o_run,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_cksum_err
);

  localparam int NB_BYTES = NB_WORD / 8;
  localparam int CNT_W    = $clog2(NB_BYTES + 1);

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_PAUSE = 8'h50;
  localparam logic [7:0] CMD_DUMP  = 8'h44;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DUMP,
    ST_DUMP_WAIT
`ifdef DEBUG_LOADER_CHECKSUM_EN
    , ST_CKSUM
`endif
  } state_t;

  state_t               state_q, state_d;
  logic                 wr_en_q, wr_en_d;
  logic [NB_ADDR-1:0]   wr_addr_q, wr_addr_d;
  logic [NB_WORD-1:0]   wr_data_q, wr_data_d;
  logic                 step_q, step_d;
  logic                 run_q, run_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
  // Shared shift register: assembles bytes while loading, drains bytes while dumping.
  logic [NB_WORD-1:0]   shift_q, shift_d;
`ifdef DEBUG_LOADER_CHECKSUM_EN
  logic [7:0]           cksum_q, cksum_d;
  logic                 cksum_err_q, cksum_err_d;
`endif

  // Incoming byte appended below the bytes already held (MSB-first assembly).
  logic [NB_WORD+7:0]   word_ext;
  logic [NB_WORD-1:0]   assembled;
  assign word_ext  = {shift_q, i_rx_data};
  assign assembled = word_ext[NB_WORD-1:0];

  // Next-state and next-output computation for the command FSM.
  always_comb begin
    state_d    = state_q;
    wr_en_d    = 1'b0;
    step_d     = 1'b0;
    tx_start_d = 1'b0;
    // The address advances in the cycle after each write strobe.
    wr_addr_d  = wr_en_q ? (wr_addr_q + NB_ADDR'(ADDR_STEP)) : wr_addr_q;
    wr_data_d  = wr_data_q;
    run_d      = run_q;
    tx_data_d  = tx_data_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
`ifdef DEBUG_LOADER_CHECKSUM_EN
    cksum_d     = cksum_q;
    cksum_err_d = cksum_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_rx_done) begin
          case (i_rx_data)
            CMD_LOAD: begin
              // Loading a program while the pipeline free-runs is refused.
              if (!run_q) begin
                state_d    = ST_LOAD;
                wr_addr_d  = '0;
                byte_cnt_d = '0;
                shift_d    = '0;
`ifdef DEBUG_LOADER_CHECKSUM_EN
                cksum_d     = '0;
                cksum_err_d = 1'b0;
`endif
              end
            end
            CMD_STEP: begin
              if (!run_q) step_d = 1'b1;
            end
            CMD_RUN:   run_d = 1'b1;
            CMD_PAUSE: run_d = 1'b0;
            CMD_DUMP: begin
              shift_d    = i_dump_word;
              byte_cnt_d = '0;
              state_d    = ST_DUMP;
            end
            default: ;
          endcase
        end
      end
      ST_LOAD: begin
        if (i_rx_done) begin
          shift_d = assembled;
`ifdef DEBUG_LOADER_CHECKSUM_EN
          cksum_d = cksum_q ^ i_rx_data;
`endif
          if (byte_cnt_q == CNT_W'(NB_BYTES - 1)) begin
            wr_en_d    = 1'b1;
            wr_data_d  = assembled;
            byte_cnt_d = '0;
            // The halt word is itself written before loading stops.
            if (assembled == HALT_WORD) begin
`ifdef DEBUG_LOADER_CHECKSUM_EN
              state_d = ST_CKSUM;
`else
              state_d = ST_IDLE;
`endif
            end
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DUMP: begin
        tx_start_d = 1'b1;
        tx_data_d  = shift_q[NB_WORD-1 -: 8];
        shift_d    = shift_q << 8;
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
        state_d    = ST_DUMP_WAIT;
      end
      ST_DUMP_WAIT: begin
        if (i_tx_done) begin
          state_d = (byte_cnt_q == CNT_W'(NB_BYTES)) ? ST_IDLE : ST_DUMP;
        end
      end
`ifdef DEBUG_LOADER_CHECKSUM_EN
      ST_CKSUM: begin
        if (i_rx_done) begin
          if (i_rx_data != cksum_q) cksum_err_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      step_q     <= 1'b0;
      run_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
`ifdef DEBUG_LOADER_CHECKSUM_EN
      cksum_q     <= '0;
      cksum_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      step_q     <= step_d;
      run_q      <= run_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
`ifdef DEBUG_LOADER_CHECKSUM_EN
      cksum_q     <= cksum_d;
      cksum_err_q <= cksum_err_d;
`endif
    end
  end

  assign o_wr_en    = wr_en_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_step     = step_q;
  assign o_run      = run_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = (state_q != ST_IDLE);
`ifdef DEBUG_LOADER_CHECKSUM_EN
  assign o_cksum_err = cksum_err_q;
`else
  assign o_cksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_debug_loader.sv
// Bench for uart_debug_loader: directed command sequence with a write/transmit
// scoreboard. A second instance with a 4-bit address checks address wrap.
module tb_uart_debug_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        tx_done = 1'b0;
  logic [31:0] dump_word;

  logic        o_wr_en, o_step, o_run, o_tx_start, o_busy, o_cksum_err;
  logic [31:0] o_wr_addr, o_wr_data;
  logic [7:0]  o_tx_data;

  logic        w_wr_en, w_step, w_run, w_tx_start, w_busy, w_cksum_err;
  logic [3:0]  w_wr_addr;
  logic [31:0] w_wr_data;
  logic [7:0]  w_tx_data;

  uart_debug_loader dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .i_dump_word(dump_word),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_step(o_step), .o_run(o_run), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .o_busy(o_busy), .o_cksum_err(o_cksum_err)
  );

  uart_debug_loader #(.NB_ADDR(4)) dut_w (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .i_dump_word(dump_word),
    .o_wr_en(w_wr_en), .o_wr_addr(w_wr_addr), .o_wr_data(w_wr_data),
    .o_step(w_step), .o_run(w_run), .o_tx_data(w_tx_data),
    .o_tx_start(w_tx_start), .o_busy(w_busy), .o_cksum_err(w_cksum_err)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_wr_q[$];
  logic [35:0] exp_ww_q[$];
  logic [7:0]  exp_tx_q[$];
  int          step_seen = 0;
  int          step_exp  = 0;
  logic [31:0] addr_model;
  logic [7:0]  ck_model;
  logic [63:0] mon_wr;
  logic [35:0] mon_ww;
  logic [7:0]  mon_tx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops expectations whenever a strobe appears
  always @(negedge clk) begin
    if (!rst) begin
      check("strobe_exclusive", 64'($onehot0({o_wr_en, o_step, o_tx_start})), 64'd1);
      if (o_wr_en) begin
        check("wr_expected", 64'(exp_wr_q.size() != 0), 64'd1);
        if (exp_wr_q.size() != 0) begin
          mon_wr = exp_wr_q.pop_front();
          check("wr_addr_data", {o_wr_addr, o_wr_data}, mon_wr);
        end
      end
      if (w_wr_en) begin
        check("wrap_wr_expected", 64'(exp_ww_q.size() != 0), 64'd1);
        if (exp_ww_q.size() != 0) begin
          mon_ww = exp_ww_q.pop_front();
          check("wrap_wr_addr_data", 64'({w_wr_addr, w_wr_data}), 64'(mon_ww));
        end
      end
      if (o_tx_start) begin
        check("tx_expected", 64'(exp_tx_q.size() != 0), 64'd1);
        if (exp_tx_q.size() != 0) begin
          mon_tx = exp_tx_q.pop_front();
          check("tx_byte", 64'(o_tx_data), 64'(mon_tx));
        end
      end
      if (o_step) step_seen++;
    end
  end

  // Transmitter model: byte finished 20 cycles after each start
  always @(negedge clk) begin
    if (o_tx_start) begin
      repeat (20) @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
    end
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1 rx_done = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic start_load();
    send_byte(8'h4C);
    addr_model = '0;
    ck_model   = '0;
  endtask

  task automatic load_word(input logic [31:0] w);
    exp_wr_q.push_back({addr_model, w});
    exp_ww_q.push_back({addr_model[3:0], w});
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
      ck_model = ck_model ^ w[i*8 +: 8];
    end
    addr_model = addr_model + 32'd4;
  endtask

  task automatic finish_load(input string tag);
`ifdef DEBUG_LOADER_CHECKSUM_EN
    send_byte(ck_model);
    check({tag, "_cksum_ok"}, 64'(o_cksum_err), 64'd0);
`endif
    check({tag, "_idle"}, 64'(o_busy), 64'd0);
    check({tag, "_all_written"}, 64'(exp_wr_q.size()), 64'd0);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (o_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(o_busy), 64'd0);
  endtask

  // Directed sequence
  initial begin
    rst       = 1'b1;
    rx_data   = '0;
    rx_done   = 1'b0;
    dump_word = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_wr_en", 64'(o_wr_en), 64'd0);
    check("rst_wr_addr", 64'(o_wr_addr), 64'd0);
    check("rst_run", 64'(o_run), 64'd0);
    check("rst_tx_start", 64'(o_tx_start), 64'd0);
    check("rst_tx_data", 64'(o_tx_data), 64'd0);
    check("rst_cksum_err", 64'(o_cksum_err), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Two-word load ending in the halt word
    start_load();
    check("load_busy", 64'(o_busy), 64'd1);
    load_word(32'h12345678);
    load_word(32'hFFFFFFFF);
    finish_load("load");
    check("load_addr_advanced", 64'(o_wr_addr), 64'd8);

    // Dump, with a received byte during the transfer that must be ignored
    dump_word = 32'hDEADBEEF;
    exp_tx_q.push_back(8'hDE);
    exp_tx_q.push_back(8'hAD);
    exp_tx_q.push_back(8'hBE);
    exp_tx_q.push_back(8'hEF);
    send_byte(8'h44);
    dump_word = 32'h0;
    repeat (10) @(posedge clk);
    send_byte(8'h4C);
    wait_idle(300, "dump_done_idle");
    check("dump_all_sent", 64'(exp_tx_q.size()), 64'd0);
    repeat (5) @(posedge clk);
    check("dump_rx_ignored", 64'(o_busy), 64'd0);
    check("dump_tx_data_held", 64'(o_tx_data), 64'hEF);

    // Run / step / pause
    send_byte(8'h52);
    check("run_set", 64'(o_run), 64'd1);
    send_byte(8'h53);
    check("step_blocked_in_run", 64'(step_seen), 64'(step_exp));
    send_byte(8'h4C);
    check("load_blocked_in_run", 64'(o_busy), 64'd0);
    send_byte(8'h50);
    check("run_cleared", 64'(o_run), 64'd0);
    step_exp++;
    send_byte(8'h53);
    check("step_pulse", 64'(step_seen), 64'(step_exp));

    // Reset during a partial load discards the word
    send_byte(8'h4C);
    send_byte(8'h12);
    send_byte(8'h34);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_async_mid_load", 64'(o_busy), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    start_load();
    load_word(32'hAABBCCDD);
    load_word(32'hFFFFFFFF);
    finish_load("reload");

    // Reset during a dump stops further transmit requests
    dump_word = 32'hCAFEF00D;
    exp_tx_q.push_back(8'hCA);
    send_byte(8'h44);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_async_mid_dump", 64'(o_busy), 64'd0);
    check("rst_tx_data_clear", 64'(o_tx_data), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (60) @(posedge clk);
    check("dump_abort_first_only", 64'(exp_tx_q.size()), 64'd0);
    check("dump_abort_idle", 64'(o_busy), 64'd0);

    // Checksum byte after the halt word
    start_load();
    load_word(32'h01020304);
    load_word(32'hFFFFFFFF);
`ifdef DEBUG_LOADER_CHECKSUM_EN
    check("cksum_model", 64'(ck_model), 64'h04);
    send_byte(8'h04);
    check("cksum_match", 64'(o_cksum_err), 64'd0);
    start_load();
    load_word(32'h01020304);
    load_word(32'hFFFFFFFF);
    send_byte(8'h05);
    check("cksum_mismatch", 64'(o_cksum_err), 64'd1);
    check("cksum_then_idle", 64'(o_busy), 64'd0);
    start_load();
    check("cksum_cleared_at_load", 64'(o_cksum_err), 64'd0);
    load_word(32'hFFFFFFFF);
    finish_load("cksum_reload");
`else
    send_byte(8'h05);
    check("no_cksum_err", 64'(o_cksum_err), 64'd0);
    check("no_cksum_state", 64'(o_busy), 64'd0);
`endif

    // Address wrap on the 4-bit instance: 0,4,8,C,0
    start_load();
    load_word(32'h11111111);
    load_word(32'h22222222);
    load_word(32'h33333333);
    load_word(32'h44444444);
    load_word(32'hFFFFFFFF);
    finish_load("wrap");
    check("wrap_all_written", 64'(exp_ww_q.size()), 64'd0);
    check("wide_addr_no_wrap", 64'(o_wr_addr), 64'h14);
    check("wrap_addr_after", 64'(w_wr_addr), 64'h4);
    check("steps_total", 64'(step_seen), 64'(step_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
